// File: rtl/memory_ctrl.sv
// memory_ctrl: 2**M x N word store with a fixed-latency access FSM.
// Ports:
//   Clock/Reset (async, active-high)
//   Req/RW/Select/WriteData: access request, captured on the accept edge
//   Clear: sequential zeroing of every word
//   ReadData: last read result
//   Ack: one-cycle completion pulse
//   Busy: high outside IDLE
module memory_ctrl #(
  parameter int N    = 8,
  parameter int M    = 3,
  parameter int WAIT = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Req,
  input  logic         RW,
  input  logic [M-1:0] Select,
  input  logic [N-1:0] WriteData,
  input  logic         Clear,
  output logic [N-1:0] ReadData,
  output logic         Ack,
  output logic         Busy
);

  localparam int DEPTH = 1 << M;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CLEAR
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [M-1:0]   ptr_q, ptr_d;
  logic [M-1:0]   addr_q, addr_d;
  logic           rw_q, rw_d;
  logic [N-1:0]   wdata_q, wdata_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic           ack_q, ack_d;
  logic [N-1:0]   mem_q [DEPTH];
  logic [N-1:0]   mem_d [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        // Clear takes priority over a simultaneous Req
        if (Clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (Req) begin
          state_d = ACCESS;
          addr_d  = Select;
          rw_d    = RW;
          wdata_d = WriteData;
          cnt_d   = 4'(WAIT);
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rw_q) begin
            mem_d[addr_q] = wdata_q;
          end else begin
            rdata_d = mem_q[addr_q];
          end
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CLEAR: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + 1'b1;
        if (&ptr_q) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ReadData = rdata_q;
  assign Ack      = ack_q;
  assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_memory_ctrl.sv
// tb_memory_ctrl: randomized and directed bench for memory_ctrl
// against an array model of the word store and read register.
module tb_memory_ctrl;

  localparam int N     = 8;
  localparam int M     = 3;
  localparam int WAIT  = 2;
  localparam int DEPTH = 1 << M;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Req;
  logic         RW;
  logic [M-1:0] Select;
  logic [N-1:0] WriteData;
  logic         Clear;
  logic [N-1:0] ReadData;
  logic         Ack;
  logic         Busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [N-1:0] ref_mem [DEPTH];
  logic [N-1:0] ref_rd;

  bit           use_mess;
  logic [M-1:0] mess_sel;
  logic [N-1:0] mess_wd;

  memory_ctrl #(.N(N), .M(M), .WAIT(WAIT)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req       (Req),
    .RW        (RW),
    .Select    (Select),
    .WriteData (WriteData),
    .Clear     (Clear),
    .ReadData  (ReadData),
    .Ack       (Ack),
    .Busy      (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_zero();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Disturb every input while busy; none of it may matter.
  task automatic scramble();
    Req       = 1'($urandom);
    Clear     = 1'($urandom);
    RW        = 1'($urandom);
    Select    = use_mess ? mess_sel : M'($urandom);
    WriteData = use_mess ? mess_wd : N'($urandom);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int  lat  = 0;
    int  nb   = 0;
    bit  done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge Clock);
      if (Ack) begin
        done  = 1;
        Req   = 1'b0;
        Clear = 1'b0;
      end else begin
        lat++;
        if (Busy) nb++;
        scramble();
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'(0), 64'(1));
      Req   = 1'b0;
      Clear = 1'b0;
    end else begin
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_busy"}, 64'(nb), 64'(exp_lat));
      check({tag, "_busy_ack"}, 64'(Busy), 64'(0));
    end
  endtask

  task automatic access(input bit rw, input int addr, input int wd,
                        input string tag);
    Req       = 1'b1;
    Clear     = 1'b0;
    RW        = rw;
    Select    = M'(addr);
    WriteData = N'(wd);
    wait_done(WAIT + 1, tag);
    if (rw) ref_mem[addr] = N'(wd);
    else    ref_rd = ref_mem[addr];
    check({tag, "_rdata"}, 64'(ReadData), 64'(ref_rd));
  endtask

  task automatic do_clear(input string tag);
    Clear = 1'b1;
    Req   = 1'b1;
    RW    = 1'($urandom);
    wait_done(DEPTH, tag);
    ref_zero();
    check({tag, "_rdata"}, 64'(ReadData), 64'(ref_rd));
    @(negedge Clock);
    check({tag, "_ack_once"}, 64'(Ack), 64'(0));
  endtask

  initial begin
    use_mess  = 0;
    mess_sel  = '0;
    mess_wd   = '0;
    Reset     = 1'b1;
    Req       = 1'b0;
    RW        = 1'b0;
    Clear     = 1'b0;
    Select    = '0;
    WriteData = '0;
    ref_zero();
    ref_rd = '0;
    #1;
    check("rst_busy", 64'(Busy), 64'(0));
    check("rst_ack", 64'(Ack), 64'(0));
    check("rst_rdata", 64'(ReadData), 64'(0));
    @(negedge Clock);
    Reset = 1'b0;

    for (int a = 0; a < DEPTH; a++) access(0, a, 0, "rd_init");

    access(1, 5, 'hAA, "wr5");
    access(0, 5, 0, "rd5");
    access(0, 4, 0, "rd4");
    access(0, 6, 0, "rd6");

    use_mess = 1;
    mess_sel = M'(3);
    mess_wd  = 8'hFF;
    access(1, 0, 74, "wr0_mess");
    use_mess = 0;
    access(0, 0, 0, "rd0");
    access(0, 3, 0, "rd3");

    // Held read request: one completion every WAIT+2 cycles
    Req    = 1'b1;
    RW     = 1'b0;
    Select = M'(5);
    Clear  = 1'b0;
    begin
      int acks = 0;
      for (int i = 1; i <= 16; i++) begin
        @(negedge Clock);
        check("strm_busy", 64'(Busy), 64'(!Ack));
        check("strm_ack", 64'(Ack), 64'((i % (WAIT + 2)) == 0));
        if (Ack) begin
          acks++;
          check("strm_rdata", 64'(ReadData), 64'(ref_mem[5]));
        end
        if (i == 16) Req = 1'b0;
      end
      check("strm_acks", 64'(acks), 64'(16 / (WAIT + 2)));
      ref_rd = ref_mem[5];
    end

    for (int a = 0; a < DEPTH; a++) access(1, a, 'h11 * (a + 1), "fill");
    do_clear("clr");
    for (int a = 0; a < DEPTH; a++) access(0, a, 0, "rd_clr");

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_clear("rnd_clr");
      end else begin
        access(1'($urandom), int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(0, 255)), "rnd");
      end
    end

    access(1, 1, 'h3C, "pre_rst_wr");
    access(0, 1, 0, "pre_rst_rd");

    // Reset in the cycle before the completion edge of a write
    Req       = 1'b1;
    RW        = 1'b1;
    Select    = M'(2);
    WriteData = 8'h55;
    @(negedge Clock);
    Req = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(Busy), 64'(0));
    check("mid_rst_ack", 64'(Ack), 64'(0));
    check("mid_rst_rdata", 64'(ReadData), 64'(0));
    @(negedge Clock);
    check("mid_rst_ack2", 64'(Ack), 64'(0));
    Reset = 1'b0;
    ref_zero();
    ref_rd = '0;
    @(negedge Clock);
    check("post_rst_ack", 64'(Ack), 64'(0));
    access(0, 2, 0, "rd2_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
